// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared types and constants for the MIPS pipeline control blocks
package mips_pipe_pkg;
   typedef enum logic {RUN, MWAIT} state_t;
   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = '0;
   localparam int MEM_TIMEOUT_DEF = 15;
endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: 32-bit performance counter that saturates at all ones
module hazard_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        inc,
   output logic [31:0] count
);
   always_ff @(posedge clk)
      if (rst) count <= '0;
      else if (en && inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush scheduler for load-use, taken-branch and memory-wait hazards
// HAZ_PERF_EN enables the stall_cycles/flush_count perf counters
module pipe_hazard_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_memr,
   input  logic             ex_regw,
   input  logic [REG_W-1:0] ex_rdst,
   input  logic             ex_branch_taken,
   input  logic             mem_access,
   input  logic             dmem_ready,
   output logic             pc_hold,
   output logic             ifid_stall,
   output logic             idex_stall,
   output logic             exmem_stall,
   output logic             memwb_stall,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             mem_err,
   output logic [31:0]      stall_cycles,
   output logic [31:0]      flush_count
);
   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   state_t state, state_n;
   logic [CW-1:0] wait_cnt, wait_cnt_n;
   logic pend, tmo, stl, br, lu;
   always_comb begin
      pend = mem_access & ~dmem_ready;
      tmo = pend && state == MWAIT && wait_cnt == CW'(MEM_TIMEOUT);
      stl = pend & ~tmo;
      br = ~stl & ex_branch_taken;
      lu = ~stl & ~br & ex_memr & ex_regw & (ex_rdst != REG_ZERO) &
           ((ex_rdst == id_rs) | (id_uses_rt & (ex_rdst == id_rt)));
      state_n = stl ? MWAIT : RUN;
      wait_cnt_n = stl ? wait_cnt + 1'b1 : '0;
   end
   always_ff @(posedge clk)
      if (rst) begin
         state <= RUN;
         wait_cnt <= '0;
         mem_err <= 1'b0;
      end else begin
         state <= state_n;
         wait_cnt <= wait_cnt_n;
         mem_err <= mem_err | tmo;
      end
   assign pc_hold = stl | lu;
   assign ifid_stall = stl | lu;
   assign idex_stall = stl;
   assign exmem_stall = stl;
   assign memwb_stall = 1'b0;
   assign ifid_flush = br;
   assign idex_flush = br | lu;
   assign exmem_flush = tmo;
   assign memwb_flush = stl | tmo;
`ifdef HAZ_PERF_EN
   hazard_perf_cnt u_stall (.clk(clk), .rst(rst), .en(1'b1), .inc(pc_hold), .count(stall_cycles));
   hazard_perf_cnt u_flush (.clk(clk), .rst(rst), .en(1'b1), .inc(br), .count(flush_count));
`else
   assign stall_cycles = '0;
   assign flush_count = '0;
`endif
endmodule
